// File: rtl/base_sampler_pkg.sv
// Shared definitions for the base sampler: nucleotide codes, FSM states and
// default widths.
package base_sampler_pkg;

  localparam int RAND_W_DEF = 10;
  localparam int LEN_W_DEF  = 16;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/base_sampler_if.sv
// Valid/ready base stream from the sampler toward the sequence writer.
interface base_sampler_if;
  logic [1:0] base_out;
  logic       base_valid;
  logic       base_ready;
  logic       base_last;

  modport master (output base_out, output base_valid, output base_last, input base_ready);
  modport slave  (input base_out, input base_valid, input base_last, output base_ready);
endinterface

// File: rtl/base_classify.sv
// Maps one random sample to a nucleotide code with cumulative thresholds.
// Priority order A, C, G, T; thresholds need not be monotone.
module base_classify
  import base_sampler_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF
) (
  input  logic [RAND_W-1:0] r,
  input  logic [RAND_W-1:0] thr_a,
  input  logic [RAND_W-1:0] thr_c,
  input  logic [RAND_W-1:0] thr_g,
  output logic [1:0]        code
);

  // First threshold the sample falls under wins; fall through to T
  always_comb begin
    code = BASE_T;
    if (r < thr_a)      code = BASE_A;
    else if (r < thr_c) code = BASE_C;
    else if (r < thr_g) code = BASE_G;
  end

endmodule

// File: rtl/base_sampler.sv
// Samples the LFSR stream, classifies each sample into a base and emits a
// sequence of seq_len bases on a valid/ready stream, with per-base histograms.
module base_sampler
  import base_sampler_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RAND_W-1:0] rand_val,
  input  logic [RAND_W-1:0] thr_a,
  input  logic [RAND_W-1:0] thr_c,
  input  logic [RAND_W-1:0] thr_g,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  base_sampler_if.master    bs,
  output logic [LEN_W-1:0]  cnt_a,
  output logic [LEN_W-1:0]  cnt_c,
  output logic [LEN_W-1:0]  cnt_g,
  output logic [LEN_W-1:0]  cnt_t
);

  state_t state_q, state_d;

  logic [RAND_W-1:0] thr_a_q, thr_c_q, thr_g_q;
  logic [LEN_W-1:0]  rem_q;
  logic [1:0]        cls_p0;
  logic [1:0]        base_p1;
  logic              vld_p1;
  logic              last_p1;
  logic              accept, hs, final_hs, capture;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign accept   = (state_q == ST_IDLE) && start;
  assign hs       = vld_p1 && bs.base_ready;
  assign final_hs = hs && last_p1;
  // Refill the output register when it is empty or draining this cycle
  assign capture  = (state_q == ST_RUN) && (!vld_p1 || hs) && (rem_q != '0);

  // Stage p0: classify the live sample against the latched thresholds
  base_classify #(.RAND_W(RAND_W)) u_classify (
    .r     (rand_val),
    .thr_a (thr_a_q),
    .thr_c (thr_c_q),
    .thr_g (thr_g_q),
    .code  (cls_p0)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status decode
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (seq_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (final_hs) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration is frozen at start; remaining count tracks captures
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_a_q <= '0;
      thr_c_q <= '0;
      thr_g_q <= '0;
      rem_q   <= '0;
    end else if (accept) begin
      thr_a_q <= thr_a;
      thr_c_q <= thr_c;
      thr_g_q <= thr_g;
      rem_q   <= seq_len;
    end else if (capture) begin
      rem_q   <= rem_q - LEN_W'(1);
    end
  end

  // Stage p1: output register, held while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (capture) begin
      base_p1 <= cls_p0;
      vld_p1  <= 1'b1;
      last_p1 <= (rem_q == LEN_W'(1));
    end else if (hs) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  // Saturating per-base histogram, cleared at each accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_c <= '0;
      cnt_g <= '0;
      cnt_t <= '0;
    end else if (accept) begin
      cnt_a <= '0;
      cnt_c <= '0;
      cnt_g <= '0;
      cnt_t <= '0;
    end else if (hs) begin
      case (base_p1)
        BASE_A:  cnt_a <= sat_inc(cnt_a);
        BASE_C:  cnt_c <= sat_inc(cnt_c);
        BASE_G:  cnt_g <= sat_inc(cnt_g);
        default: cnt_t <= sat_inc(cnt_t);
      endcase
    end
  end

  assign bs.base_out   = base_p1;
  assign bs.base_valid = vld_p1;
  assign bs.base_last  = last_p1;

endmodule

// File: tb/tb_base_sampler.sv
// Testbench for base_sampler: classification table, directed corner-case
// sequences and randomized runs against a transaction-level reference model.
module tb_base_sampler;
  import base_sampler_pkg::*;

  localparam int RW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] rand_val = '0;
  logic [RW-1:0] thr_a = '0, thr_c = '0, thr_g = '0;
  logic [LW-1:0] seq_len = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [LW-1:0] cnt_a, cnt_c, cnt_g, cnt_t;

  base_sampler_if bif();

  base_sampler #(.RAND_W(RW), .LEN_W(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rand_val (rand_val),
    .thr_a    (thr_a),
    .thr_c    (thr_c),
    .thr_g    (thr_g),
    .seq_len  (seq_len),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bs       (bif),
    .cnt_a    (cnt_a),
    .cnt_c    (cnt_c),
    .cnt_g    (cnt_g),
    .cnt_t    (cnt_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] b;
    logic       last;
  } item_t;

  typedef struct {
    logic [RW-1:0] ta;
    logic [RW-1:0] tc;
    logic [RW-1:0] tg;
    logic [RW-1:0] r;
    logic [1:0]    exp;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: phase 0 idle, 1 running, 2 done cycle
  int            m_state = 0;
  int            m_rem = 0;
  logic [RW-1:0] m_ta = '0, m_tc = '0, m_tg = '0;
  item_t         q[$];
  int            hist[4];
  int            hs_count = 0;
  logic [1:0]    hs_log[$];
  logic          stall_prev = 1'b0;
  logic [1:0]    prev_b = '0;
  logic          prev_last = 1'b0;

  // Stimulus controls
  int            rv_mode = 0;
  int            rdy_pct = 100;
  logic [RW-1:0] lfsr = 10'd1;
  logic [RW-1:0] rv_const = '0;
  logic [RW-1:0] rv_list[$];
  logic          hold_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_cls(input logic [RW-1:0] r, input logic [RW-1:0] a,
                                         input logic [RW-1:0] c, input logic [RW-1:0] g);
    int ri, ai, ci, gi;
    ri = int'(r); ai = int'(a); ci = int'(c); gi = int'(g);
    if (ri < ai) return 2'd0;
    if (ri < ci) return 2'd1;
    if (ri < gi) return 2'd2;
    return 2'd3;
  endfunction

  task automatic drive_inputs();
    case (rv_mode)
      0: rand_val = RW'($urandom_range(0, 1023));
      1: begin
        rand_val = lfsr;
        lfsr = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      end
      2: rand_val = (rv_list.size() > 0) ? rv_list.pop_front() : '0;
      default: rand_val = rv_const;
    endcase
    bif.base_ready = ($urandom_range(0, 99) < rdy_pct);
    start = hold_start && (m_state == 1);
  endtask

  // One clock cycle: called at a negedge with inputs driven, checks the DUT
  // against the model, advances the model across the next posedge.
  task automatic cycle();
    int    nxt;
    logic  hs;
    item_t it;
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("done", 32'(done), 32'(m_state == 2));
    if (stall_prev) begin
      chk("hold_base", 32'(bif.base_out), 32'(prev_b));
      chk("hold_last", 32'(bif.base_last), 32'(prev_last));
    end
    stall_prev = 1'b0;
    nxt = m_state;
    if (m_state == 0) begin
      chk("valid_idle", 32'(bif.base_valid), 32'd0);
      if (start) begin
        m_ta = thr_a; m_tc = thr_c; m_tg = thr_g;
        m_rem = int'(seq_len);
        hist = '{0, 0, 0, 0};
        hs_count = 0;
        hs_log.delete();
        q.delete();
        nxt = (seq_len == '0) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      chk("valid", 32'(bif.base_valid), 32'(q.size() != 0));
      hs = bif.base_valid && bif.base_ready;
      if (bif.base_valid && !bif.base_ready) begin
        stall_prev = 1'b1;
        prev_b = bif.base_out;
        prev_last = bif.base_last;
      end
      if (hs && q.size() > 0) begin
        it = q.pop_front();
        chk("base", 32'(bif.base_out), 32'(it.b));
        chk("last", 32'(bif.base_last), 32'(it.last));
        hist[it.b]++;
        hs_count++;
        hs_log.push_back(it.b);
        if (it.last) nxt = 2;
      end
      if (q.size() == 0 && m_rem > 0) begin
        q.push_back('{b: ref_cls(rand_val, m_ta, m_tc, m_tg), last: (m_rem == 1)});
        m_rem--;
      end
    end else begin
      chk("valid_done", 32'(bif.base_valid), 32'd0);
      chk("cnt_a", 32'(cnt_a), 32'(hist[0]));
      chk("cnt_c", 32'(cnt_c), 32'(hist[1]));
      chk("cnt_g", 32'(cnt_g), 32'(hist[2]));
      chk("cnt_t", 32'(cnt_t), 32'(hist[3]));
      nxt = 0;
    end
    m_state = nxt;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bif.base_valid), 32'd0);
    chk("rst_base", 32'(bif.base_out), 32'd0);
    chk("rst_last", 32'(bif.base_last), 32'd0);
    chk("rst_cnt", 32'({cnt_a, cnt_c} | {cnt_g, cnt_t}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_state = 0; m_rem = 0; q.delete(); stall_prev = 1'b0;
  endtask

  task automatic run_seq(input logic [RW-1:0] a, input logic [RW-1:0] c,
                         input logic [RW-1:0] g, input logic [LW-1:0] len,
                         input int budget);
    int n = 0;
    drive_inputs();
    thr_a = a; thr_c = c; thr_g = g; seq_len = len; start = 1'b1;
    cycle();
    start = 1'b0;
    thr_a = RW'($urandom); thr_c = RW'($urandom); thr_g = RW'($urandom);
    seq_len = LW'($urandom);
    while (m_state != 0 && n < budget) begin
      drive_inputs();
      cycle();
      n++;
    end
    chk("run_ends", 32'(m_state == 0), 32'd1);
    if (m_state != 0) do_reset();
  endtask

  vec_t       tbl[13];
  logic [1:0] e1[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.base_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_valid", 32'(bif.base_valid), 32'd0);
    chk("reset_base", 32'(bif.base_out), 32'd0);
    chk("reset_last", 32'(bif.base_last), 32'd0);
    chk("reset_cnt", 32'({cnt_a, cnt_c} | {cnt_g, cnt_t}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed stream: 100,256,511,768,1023 on the five capture cycles
    rv_mode = 2; rdy_pct = 100;
    rv_list = '{10'd0, 10'd100, 10'd256, 10'd511, 10'd768, 10'd1023};
    e1 = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    run_seq(10'd256, 10'd512, 10'd768, 16'd5, 20);
    chk("t1_count", 32'(hs_count), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < hs_log.size()) chk("t1_base", 32'(hs_log[i]), 32'(e1[i]));
    chk("t1_cnt_a", 32'(cnt_a), 32'd1);
    chk("t1_cnt_c", 32'(cnt_c), 32'd2);
    chk("t1_cnt_g", 32'(cnt_g), 32'd0);
    chk("t1_cnt_t", 32'(cnt_t), 32'd2);

    // Classification table, one base per run with a constant sample
    tbl[0]  = '{10'd256, 10'd512, 10'd768, 10'd100,  2'd0};
    tbl[1]  = '{10'd256, 10'd512, 10'd768, 10'd256,  2'd1};
    tbl[2]  = '{10'd256, 10'd512, 10'd768, 10'd511,  2'd1};
    tbl[3]  = '{10'd256, 10'd512, 10'd768, 10'd768,  2'd3};
    tbl[4]  = '{10'd256, 10'd512, 10'd768, 10'd1023, 2'd3};
    tbl[5]  = '{10'd256, 10'd512, 10'd768, 10'd255,  2'd0};
    tbl[6]  = '{10'd256, 10'd512, 10'd768, 10'd767,  2'd2};
    tbl[7]  = '{10'd0,   10'd512, 10'd768, 10'd0,    2'd1};
    tbl[8]  = '{10'd800, 10'd100, 10'd300, 10'd500,  2'd0};
    tbl[9]  = '{10'd0,   10'd0,   10'd0,   10'd5,    2'd3};
    tbl[10] = '{10'd1023,10'd1023,10'd1023,10'd1023, 2'd3};
    tbl[11] = '{10'd0,   10'd1,   10'd1,   10'd0,    2'd1};
    tbl[12] = '{10'd512, 10'd512, 10'd1000,10'd600,  2'd2};
    rv_mode = 3;
    for (int i = 0; i < 13; i++) begin
      rv_const = tbl[i].r;
      run_seq(tbl[i].ta, tbl[i].tc, tbl[i].tg, 16'd1, 10);
      chk("tbl_count", 32'(hs_count), 32'd1);
      if (hs_log.size() > 0) chk("tbl_base", 32'(hs_log[0]), 32'(tbl[i].exp));
    end

    // Backpressure: five stalled cycles right after the first valid
    rv_mode = 0; rdy_pct = 100;
    drive_inputs();
    thr_a = 10'd256; thr_c = 10'd512; thr_g = 10'd768; seq_len = 16'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 40 && m_state != 0; k++) begin
      drive_inputs();
      bif.base_ready = !(k >= 1 && k <= 5);
      cycle();
    end
    chk("bp_ends", 32'(m_state == 0), 32'd1);
    chk("bp_count", 32'(hs_count), 32'd3);

    // Zero-length run, then a run with start held high throughout
    run_seq(10'd256, 10'd512, 10'd768, 16'd0, 5);
    chk("zero_count", 32'(hs_count), 32'd0);
    hold_start = 1'b1;
    run_seq(10'd300, 10'd600, 10'd900, 16'd6, 40);
    hold_start = 1'b0;
    chk("hold_count", 32'(hs_count), 32'd6);

    // Reset with two bases sent and a third pending
    rdy_pct = 100;
    drive_inputs();
    thr_a = 10'd256; thr_c = 10'd512; thr_g = 10'd768; seq_len = 16'd8; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 20 && hs_count < 2; k++) begin
      drive_inputs();
      cycle();
    end
    chk("mid_sent", 32'(hs_count), 32'd2);
    chk("mid_pending", 32'(bif.base_valid), 32'd1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_inputs();
      cycle();
    end
    run_seq(10'd256, 10'd512, 10'd768, 16'd8, 40);
    chk("fresh_count", 32'(hs_count), 32'd8);

    // Long run fed by an LFSR with random backpressure
    rv_mode = 1; lfsr = 10'd1; rdy_pct = 60;
    run_seq(10'd256, 10'd512, 10'd768, 16'd1000, 6000);
    chk("lfsr_count", 32'(hs_count), 32'd1000);

    // Randomized runs
    rv_mode = 0;
    for (int t = 0; t < 12; t++) begin
      int len;
      len = int'($urandom_range(1, 40));
      rdy_pct = int'($urandom_range(20, 100));
      hold_start = $urandom_range(0, 1) == 1;
      run_seq(RW'($urandom), RW'($urandom), RW'($urandom), LW'(len), 400);
      chk("rand_count", 32'(hs_count), 32'(len));
    end
    hold_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/base_sampler.md
Name: base_sampler

Overview:
Consumes the free-running 10-bit pseudo-random stream from the LFSR stage and maps each sample to a 2-bit nucleotide code (A=0, C=1, G=2, T=3). The mapping uses programmable cumulative-frequency thresholds. Emits a sequence of seq_len bases on a valid/ready stream toward the sequence writer. Keeps per-base histogram counters for software and verification cross-checks.

Parameters:
RAND_W, 10, width of random input and thresholds
LEN_W, 16, width of sequence-length counter and histogram counters

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
rand_val  in  RAND_W  pseudo-random sample from upstream LFSR, new value every clk
thr_a  in  RAND_W  cumulative threshold A (r < thr_a -> A)
thr_c  in  RAND_W  cumulative threshold C
thr_g  in  RAND_W  cumulative threshold G
seq_len  in  LEN_W  number of bases to generate
start  in  1  start request, sampled in IDLE only
busy  out  1  high from start acceptance until done pulse inclusive
done  out  1  one-cycle pulse after last base handshake
base_out  out  2  nucleotide code
base_valid  out  1  base_out valid
base_ready  in  1  downstream accept
base_last  out  1  qualifies final base of sequence
cnt_a, cnt_c, cnt_g, cnt_t  out  LEN_W each  bases emitted per class in current/last run

Behaviour:
- Reset: state=IDLE; busy=0, done=0, base_valid=0, base_out=0, base_last=0, all cnt_*=0, internal remaining count=0, latched thresholds=0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1:
  - latch thr_a/c/g and seq_len; clear cnt_*; busy=1 next cycle.
  - seq_len==0 -> go to DONE directly, no base emitted.
  - otherwise -> RUN.
- start outside IDLE is ignored; threshold/seq_len input changes after latch have no effect.
- RUN, sample rule:
  - output register empty or handshake (base_valid & base_ready) this cycle, and remaining>0 -> capture class of current rand_val.
  - set base_valid=1 next cycle; decrement remaining; base_last=1 when captured sample is the final one (remaining==1 at capture).
- Classification (unsigned, strict less-than, priority order):
  - r<thr_a -> A; else r<thr_c -> C; else r<thr_g -> G; else T.
  - Non-monotone thresholds are legal; priority order defines the result.
- Handshake rules:
  - base_out/base_last held stable while base_valid=1 and base_ready=0; rand_val ignored while stalled.
  - Handshake with no further samples -> base_valid=0 next cycle.
  - Full throughput: one base per cycle with base_ready tied high.
- Latency: start accepted at cycle T; first capture at end of T+1; base_valid=1 in T+2.
- cnt_x increments by 1 on each handshake of class x; saturates at all-ones, no wrap. Values hold after done until next start.
- Final handshake (base_last=1 & base_ready) -> DONE. DONE lasts one cycle: done=1, busy=1, then IDLE with busy=0.
- start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- Reset mid-run: immediate return to reset values; pending base is discarded with no done pulse.

Decomposition:
- Shared package: base code constants (BASE_A..BASE_T = 0..3), FSM state encoding, RAND_W/LEN_W defaults.
- Natural sub-module: base_classify, purely combinational threshold compare. Instanced once; reusable by a future multi-lane sampler.

Test Plan:
1. thr=256/512/768, seq_len=5, bench drives rand_val 100,256,511,768,1023 on successive capture cycles, ready=1 -> bases 0,1,1,3,3; base_last on 5th; cnt_a=1,cnt_c=2,cnt_g=0,cnt_t=2; done pulse one cycle after 5th handshake.
2. Boundaries: rand_val=255 -> A, 767 -> G, thr_a=0 with rand 0 -> not A (C if thr_c>0). Non-monotone thr_a=800,thr_c=100, rand 500 -> A.
3. Backpressure: seq_len=3, ready low 5 cycles after first valid while rand_val toggles -> base_out constant; total 3 handshakes exactly, no drops or duplicates.
4. seq_len=0 -> no base_valid, done pulse at T+1, busy high T+1 only; start held during RUN -> ignored, exactly seq_len bases.
5. Reset asserted mid-run (2 of 8 bases sent, valid pending) -> all outputs 0 asynchronously, no done. Fresh start afterward runs a full 8.
6. Integration with LFSR (reset seed 1), thr=256/512/768, seq_len=1000, ready randomly toggled -> base stream and cnt_* match golden model of LFSR+classifier bit-exactly.
